// File: rtl/quadrant_selector_if.sv
// Button, frame and quadrant signals between the timing/button side and quadrant_selector.
// The master drives the raw buttons and frame_start. The slave drives the quadrant outputs.
interface quadrant_selector_if;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_sel;
    logic       frame_start;
    logic [2:0] quadrant;
    logic [2:0] pending;
    logic       active;

    modport master (
        output btn_next, btn_prev, btn_sel, frame_start,
        input  quadrant, pending, active
    );

    modport slave (
        input  btn_next, btn_prev, btn_sel, frame_start,
        output quadrant, pending, active
    );
endinterface

// File: rtl/quadrant_selector.sv
// Debounces three push-buttons and turns them into a frame-aligned 3-bit quadrant code.
// The code only changes on frame_start, so the highlight never tears mid-frame.
module quadrant_selector #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               clk,
    input  logic               rst_n,
    quadrant_selector_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    // Bit order: 0 = next, 1 = prev, 2 = sel
    logic [2:0] w_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_press;

    state_e     r_state;
    state_e     w_state_nxt;
    logic [2:0] r_pending;
    logic [2:0] w_pending_nxt;
    logic [2:0] r_quadrant;
    logic [2:0] w_quadrant_nxt;

    assign w_raw = {bus.btn_sel, bus.btn_prev, bus.btn_next};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_deb
        logic             r_db;
        logic [CNT_W-1:0] r_cnt;
        logic             w_diff;
        logic             w_done;

        assign w_diff = r_sync2[g] ^ r_db;
        assign w_done = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
        // Press fires on the same edge that the debounced level rises.
        assign w_press[g] = w_done && r_sync2[g];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_db  <= 1'b0;
                r_cnt <= '0;
            end else if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_db  <= r_sync2[g];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (w_press[2]) w_state_nxt = StActive;
            StActive: if (w_press[2]) w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_pending_nxt = r_pending;
        // Simultaneous next+prev cancel; illegal values recover to 1.
        if (r_state == StActive && (w_press[0] ^ w_press[1])) begin
            case (r_pending)
                3'd1:    w_pending_nxt = w_press[0] ? 3'd2 : 3'd4;
                3'd2:    w_pending_nxt = w_press[0] ? 3'd3 : 3'd1;
                3'd3:    w_pending_nxt = w_press[0] ? 3'd4 : 3'd2;
                3'd4:    w_pending_nxt = w_press[0] ? 3'd1 : 3'd3;
                default: w_pending_nxt = 3'd1;
            endcase
        end

        w_quadrant_nxt = r_quadrant;
        if (bus.frame_start) begin
            w_quadrant_nxt = (r_state == StActive) ? r_pending : 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= 3'd1;
            r_quadrant <= 3'd0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_quadrant <= w_quadrant_nxt;
        end
    end

    assign bus.quadrant = r_quadrant;
    assign bus.pending  = r_pending;
    assign bus.active   = (r_state == StActive);

endmodule

// File: tb/tb_quadrant_selector.sv
// Bench for quadrant_selector: hand-derived vector table, reset corner cases and random
// button activity, all checked every cycle against a window-based behavioural model.
module tb_quadrant_selector;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    quadrant_selector_if bus ();

    quadrant_selector #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          nxt;
        bit          prv;
        bit          sel;
        bit          fs;
        int          cyc;
        logic [2:0]  eq;
        logic [2:0]  ep;
        logic        ea;
    } vec_t;

    vec_t tbl[$];

    // Model: raw samples per edge; a level is accepted once D delayed samples all disagree.
    logic [2:0] m_hist[$];
    logic [2:0] m_db;
    bit         m_active;
    int         m_pending;
    int         m_quadrant;

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < D + 1; i++) m_hist.push_back(3'b000);
        m_db       = 3'b000;
        m_active   = 1'b0;
        m_pending  = 1;
        m_quadrant = 0;
    endfunction

    function automatic void model_edge(input logic [2:0] raw, input bit fs);
        logic [2:0] press;
        int         n;
        bit         all_diff;
        press = 3'b000;
        n     = m_hist.size();
        for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            for (int k = n - 1 - D; k <= n - 2; k++) begin
                if (m_hist[k][b] == m_db[b]) all_diff = 1'b0;
            end
            if (all_diff) begin
                if (!m_db[b]) press[b] = 1'b1;
                m_db[b] = ~m_db[b];
            end
        end
        if (fs) m_quadrant = m_active ? m_pending : 0;
        if (m_active && (press[0] ^ press[1])) begin
            if (press[0]) m_pending = (m_pending % 4) + 1;
            else          m_pending = (m_pending == 1) ? 4 : m_pending - 1;
        end
        if (press[2]) m_active = !m_active;
        m_hist.push_back(raw);
        if (m_hist.size() > D + 1) void'(m_hist.pop_front());
    endfunction

    task automatic check_model(input string name);
        vectors++;
        if (bus.quadrant !== 3'(m_quadrant) || bus.pending !== 3'(m_pending) ||
            bus.active !== m_active) begin
            miscompares++;
            $display("FAIL %s t=%0t got q=%0d p=%0d a=%0b expected q=%0d p=%0d a=%0b", name,
                     $time, bus.quadrant, bus.pending, bus.active, m_quadrant, m_pending,
                     m_active);
        end
    endtask

    task automatic check_exp(input string name, input logic [2:0] q, input logic [2:0] p,
                             input logic a);
        vectors++;
        if (bus.quadrant !== q || bus.pending !== p || bus.active !== a) begin
            miscompares++;
            $display("FAIL %s t=%0t got q=%0d p=%0d a=%0b expected q=%0d p=%0d a=%0b", name,
                     $time, bus.quadrant, bus.pending, bus.active, q, p, a);
        end
    endtask

    // Drive, clock, advance the model, then sample 1 ns after the edge.
    task automatic step(input logic n, input logic p, input logic s, input logic f);
        bus.btn_next    = n;
        bus.btn_prev    = p;
        bus.btn_sel     = s;
        bus.frame_start = f;
        @(posedge clk);
        model_edge({s, p, n}, f);
        #1;
        check_model("model");
    endtask

    function automatic void add(input bit n, input bit p, input bit s, input bit f,
                                input int c, input logic [2:0] q, input logic [2:0] pd,
                                input logic a);
        tbl.push_back('{nxt: n, prv: p, sel: s, fs: f, cyc: c, eq: q, ep: pd, ea: a});
    endfunction

    initial begin
        logic [2:0] raw;

        // Idle with periodic frame_start
        add(0, 0, 0, 0, 19, 0, 1, 0);
        add(0, 0, 0, 1, 1,  0, 1, 0);
        // Sel press: active exactly six edges after the raw rise
        add(0, 0, 1, 0, 5,  0, 1, 0);
        add(0, 0, 1, 0, 1,  0, 1, 1);
        add(0, 0, 1, 0, 4,  0, 1, 1);
        add(0, 0, 0, 0, 8,  0, 1, 1);
        add(0, 0, 0, 1, 1,  1, 1, 1);
        // Three next presses, frame_start, fourth press wraps pending
        add(1, 0, 0, 0, 6,  1, 2, 1);
        add(0, 0, 0, 0, 6,  1, 2, 1);
        add(1, 0, 0, 0, 6,  1, 3, 1);
        add(0, 0, 0, 0, 6,  1, 3, 1);
        add(1, 0, 0, 0, 6,  1, 4, 1);
        add(0, 0, 0, 0, 6,  1, 4, 1);
        add(0, 0, 0, 1, 1,  4, 4, 1);
        add(1, 0, 0, 0, 6,  4, 1, 1);
        add(0, 0, 0, 0, 6,  4, 1, 1);
        add(0, 0, 0, 0, 10, 4, 1, 1);
        add(0, 0, 0, 1, 1,  1, 1, 1);
        // Short prev glitches are rejected
        for (int i = 0; i < 5; i++) begin
            add(0, 1, 0, 0, 3, 1, 1, 1);
            add(0, 0, 0, 0, 3, 1, 1, 1);
        end
        add(0, 1, 0, 0, 6,  1, 4, 1);
        add(0, 0, 0, 0, 6,  1, 4, 1);
        add(1, 0, 0, 0, 6,  1, 1, 1);
        add(0, 0, 0, 0, 6,  1, 1, 1);
        add(1, 0, 0, 0, 6,  1, 2, 1);
        add(0, 0, 0, 0, 6,  1, 2, 1);
        // Simultaneous next+prev cancel
        add(1, 1, 0, 0, 8,  1, 2, 1);
        add(0, 0, 0, 0, 6,  1, 2, 1);
        add(1, 0, 0, 0, 6,  1, 3, 1);
        add(0, 0, 0, 0, 6,  1, 3, 1);
        add(0, 0, 0, 1, 1,  3, 3, 1);
        // Sel back to idle, then frame_start blanks
        add(0, 0, 1, 0, 6,  3, 3, 0);
        add(0, 0, 0, 0, 6,  3, 3, 0);
        add(0, 0, 0, 1, 1,  0, 3, 0);

        rst_n           = 1'b0;
        bus.btn_next    = 1'b0;
        bus.btn_prev    = 1'b0;
        bus.btn_sel     = 1'b0;
        bus.frame_start = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_exp("reset", 3'd0, 3'd1, 1'b0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].cyc; c++) begin
                step(tbl[i].nxt, tbl[i].prv, tbl[i].sel, tbl[i].fs);
            end
            check_exp($sformatf("table[%0d]", i), tbl[i].eq, tbl[i].ep, tbl[i].ea);
        end

        // Async reset mid-debounce of next
        repeat (3) step(1, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_exp("async_reset", 3'd0, 3'd1, 1'b0);
        bus.btn_next = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (10) step(0, 0, 0, 0);
        check_exp("no_press_after_reset", 3'd0, 3'd1, 1'b0);
        repeat (2) step(0, 0, 0, 1);
        check_exp("idle_frame_after_reset", 3'd0, 3'd1, 1'b0);
        repeat (6) step(0, 0, 1, 0);
        repeat (6) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check_exp("reentry", 3'd1, 3'd1, 1'b1);

        // Random button activity with occasional async reset
        raw = 3'b000;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 7) == 0) raw[b] = ~raw[b];
            end
            step(raw[0], raw[1], raw[2], $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_model("rand_reset");
                #1;
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
